// File: rtl/map_table_nway_pkg.sv
// rtl/map_table_nway_pkg.sv - sys_defs: shared rename-map types, AR zero and default widths
package map_table_nway_pkg;

  localparam int DEF_DISPATCH_W = 3;
  localparam int DEF_CDB_W      = 3;
  localparam int DEF_AR_NUM     = 32;
  localparam int DEF_PR_W       = 6;
  localparam int AR_ZERO        = 0;

  typedef logic [DEF_PR_W-1:0] pr_tag_t;

  // One completion broadcast: CDB_W tags, a zero tag means no broadcast in that lane
  typedef pr_tag_t [DEF_CDB_W-1:0] CDB_T_PACKET;

  typedef struct packed {
    pr_tag_t pr;
    logic    ready;
  } MT_ENTRY;

endpackage

// File: rtl/map_table_nway_resolve.sv
// rtl/map_table_nway_resolve.sv - older-slot priority search for intra-bundle rename forwarding
module mt_bundle_resolve
  import map_table_nway_pkg::*;
#(
  parameter int DISPATCH_W = DEF_DISPATCH_W,
  parameter int AR_W       = 5,
  parameter int PR_W       = DEF_PR_W
) (
  input  logic [DISPATCH_W-1:0]           dispatch_en,
  input  logic [DISPATCH_W-1:0][AR_W-1:0] new_ar,
  input  logic [DISPATCH_W-1:0][PR_W-1:0] new_pr,
  input  logic [DISPATCH_W-1:0][AR_W-1:0] query_ar,
  output logic [DISPATCH_W-1:0][PR_W-1:0] fwd_tag,
  output logic [DISPATCH_W-1:0]           hit
);

  // Higher index is older; scanning down leaves the youngest older writer in place.
  always_comb begin
    fwd_tag = '0;
    hit     = '0;
    for (int s = 0; s < DISPATCH_W; s++) begin
      for (int j = DISPATCH_W-1; j > s; j--) begin
        if (dispatch_en[j] && (new_ar[j] == query_ar[s])) begin
          hit[s]     = 1'b1;
          fwd_tag[s] = new_pr[j];
        end
      end
      if (query_ar[s] == AR_W'(AR_ZERO)) begin
        hit[s]     = 1'b0;
        fwd_tag[s] = '0;
      end
    end
  end

endmodule

// File: rtl/map_table_nway.sv
// rtl/map_table_nway.sv - N-wide rename map table with CDB bypass and recovery; MT_CHECKPOINT_EN adds a snapshot
module map_table_nway
  import map_table_nway_pkg::*;
#(
  parameter int DISPATCH_W = DEF_DISPATCH_W,
  parameter int CDB_W      = DEF_CDB_W,
  parameter int AR_NUM     = DEF_AR_NUM,
  parameter int PR_W       = DEF_PR_W,
  parameter int AR_W       = $clog2(AR_NUM)
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [DISPATCH_W-1:0]           dispatch_en,
  input  logic [DISPATCH_W-1:0][AR_W-1:0] maptable_new_ar,
  input  logic [DISPATCH_W-1:0][PR_W-1:0] maptable_new_pr,
  input  logic [DISPATCH_W-1:0][AR_W-1:0] reg1_ar,
  input  logic [DISPATCH_W-1:0][AR_W-1:0] reg2_ar,
  output logic [DISPATCH_W-1:0][PR_W-1:0] reg1_tag,
  output logic [DISPATCH_W-1:0][PR_W-1:0] reg2_tag,
  output logic [DISPATCH_W-1:0]           reg1_ready,
  output logic [DISPATCH_W-1:0]           reg2_ready,
  output logic [DISPATCH_W-1:0][PR_W-1:0] Told_out,
  input  logic [CDB_W-1:0][PR_W-1:0]      cdb_tag,
  input  logic                            BPRecoverEN,
  input  logic [AR_NUM-1:0][PR_W-1:0]     archi_maptable,
  output logic [AR_NUM-1:0][PR_W-1:0]     map_array_disp,
  output logic [AR_NUM-1:0]               ready_array_disp
`ifdef MT_CHECKPOINT_EN
  ,
  input  logic                            checkpoint_take,
  input  logic                            checkpoint_restore
`endif
);

  logic [PR_W-1:0]   map_q [AR_NUM];
  logic [AR_NUM-1:0] ready_q;
  logic [PR_W-1:0]   upd_map [AR_NUM];
  logic [AR_NUM-1:0] upd_ready;
  logic [PR_W-1:0]   map_n [AR_NUM];
  logic [AR_NUM-1:0] ready_n;

  logic [DISPATCH_W-1:0][PR_W-1:0] r1_fwd, r2_fwd, dest_fwd;
  logic [DISPATCH_W-1:0]           r1_hit, r2_hit, dest_hit;

  function automatic logic cdb_hit(input logic [PR_W-1:0] t,
                                   input logic [CDB_W-1:0][PR_W-1:0] c);
    cdb_hit = 1'b0;
    for (int k = 0; k < CDB_W; k++)
      if ((c[k] != '0) && (c[k] == t)) cdb_hit = 1'b1;
  endfunction

  mt_bundle_resolve #(.DISPATCH_W(DISPATCH_W), .AR_W(AR_W), .PR_W(PR_W)) u_res_reg1 (
    .dispatch_en(dispatch_en), .new_ar(maptable_new_ar), .new_pr(maptable_new_pr),
    .query_ar(reg1_ar), .fwd_tag(r1_fwd), .hit(r1_hit)
  );

  mt_bundle_resolve #(.DISPATCH_W(DISPATCH_W), .AR_W(AR_W), .PR_W(PR_W)) u_res_reg2 (
    .dispatch_en(dispatch_en), .new_ar(maptable_new_ar), .new_pr(maptable_new_pr),
    .query_ar(reg2_ar), .fwd_tag(r2_fwd), .hit(r2_hit)
  );

  mt_bundle_resolve #(.DISPATCH_W(DISPATCH_W), .AR_W(AR_W), .PR_W(PR_W)) u_res_dest (
    .dispatch_en(dispatch_en), .new_ar(maptable_new_ar), .new_pr(maptable_new_pr),
    .query_ar(maptable_new_ar), .fwd_tag(dest_fwd), .hit(dest_hit)
  );

  // Forwarded sources are never ready; table sources see this cycle's CDB.
  always_comb begin
    reg1_tag   = '0;
    reg2_tag   = '0;
    reg1_ready = '0;
    reg2_ready = '0;
    Told_out   = '0;
    for (int s = 0; s < DISPATCH_W; s++) begin
      if (reg1_ar[s] == AR_W'(AR_ZERO)) begin
        reg1_tag[s]   = '0;
        reg1_ready[s] = 1'b1;
      end else if (r1_hit[s]) begin
        reg1_tag[s]   = r1_fwd[s];
        reg1_ready[s] = 1'b0;
      end else begin
        reg1_tag[s]   = map_q[reg1_ar[s]];
        reg1_ready[s] = ready_q[reg1_ar[s]] | cdb_hit(map_q[reg1_ar[s]], cdb_tag);
      end

      if (reg2_ar[s] == AR_W'(AR_ZERO)) begin
        reg2_tag[s]   = '0;
        reg2_ready[s] = 1'b1;
      end else if (r2_hit[s]) begin
        reg2_tag[s]   = r2_fwd[s];
        reg2_ready[s] = 1'b0;
      end else begin
        reg2_tag[s]   = map_q[reg2_ar[s]];
        reg2_ready[s] = ready_q[reg2_ar[s]] | cdb_hit(map_q[reg2_ar[s]], cdb_tag);
      end

      if (maptable_new_ar[s] == AR_W'(AR_ZERO))
        Told_out[s] = '0;
      else if (dest_hit[s])
        Told_out[s] = dest_fwd[s];
      else
        Told_out[s] = map_q[maptable_new_ar[s]];
    end
  end

  always_comb begin
    for (int i = 0; i < AR_NUM; i++) map_array_disp[i] = map_q[i];
    ready_array_disp = ready_q;
  end

  // CDB first, then renames oldest to youngest so the youngest writer lands last.
  always_comb begin
    for (int i = 0; i < AR_NUM; i++) begin
      upd_map[i]   = map_q[i];
      upd_ready[i] = ready_q[i] | cdb_hit(map_q[i], cdb_tag);
    end
    for (int s = DISPATCH_W-1; s >= 0; s--) begin
      if (dispatch_en[s] && (maptable_new_ar[s] != AR_W'(AR_ZERO))) begin
        upd_map[maptable_new_ar[s]]   = maptable_new_pr[s];
        upd_ready[maptable_new_ar[s]] = 1'b0;
      end
    end
  end

`ifdef MT_CHECKPOINT_EN
  logic [PR_W-1:0]   snap_map [AR_NUM];
  logic [AR_NUM-1:0] snap_ready;
`endif

  always_comb begin
    map_n   = upd_map;
    ready_n = upd_ready;
    if (BPRecoverEN) begin
      for (int i = 0; i < AR_NUM; i++) map_n[i] = archi_maptable[i];
      ready_n = '1;
    end
`ifdef MT_CHECKPOINT_EN
    else if (checkpoint_restore) begin
      map_n = snap_map;
      for (int i = 0; i < AR_NUM; i++)
        ready_n[i] = snap_ready[i] | cdb_hit(snap_map[i], cdb_tag);
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < AR_NUM; i++) map_q[i] <= PR_W'(i);
      ready_q <= '1;
    end else begin
      map_q   <= map_n;
      ready_q <= ready_n;
    end
  end

`ifdef MT_CHECKPOINT_EN
  // Snapshot keeps absorbing completions so a later restore sees them.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < AR_NUM; i++) snap_map[i] <= PR_W'(i);
      snap_ready <= '1;
    end else if (checkpoint_take && !checkpoint_restore && !BPRecoverEN) begin
      snap_map   <= upd_map;
      snap_ready <= upd_ready;
    end else begin
      for (int i = 0; i < AR_NUM; i++)
        snap_ready[i] <= snap_ready[i] | cdb_hit(snap_map[i], cdb_tag);
    end
  end
`endif

endmodule

// File: tb/tb_map_table_nway.sv
// tb/tb_map_table_nway.sv - directed and randomized checks of map_table_nway against a sequential rename model
module tb_map_table_nway;
  localparam int DW = 3;
  localparam int CW = 3;
  localparam int AN = 32;
  localparam int PW = 6;
  localparam int AW = 5;

  logic clock = 1'b0;
  logic reset;
  logic [DW-1:0]         dispatch_en;
  logic [DW-1:0][AW-1:0] maptable_new_ar;
  logic [DW-1:0][PW-1:0] maptable_new_pr;
  logic [DW-1:0][AW-1:0] reg1_ar, reg2_ar;
  logic [DW-1:0][PW-1:0] reg1_tag, reg2_tag, Told_out;
  logic [DW-1:0]         reg1_ready, reg2_ready;
  logic [CW-1:0][PW-1:0] cdb_tag;
  logic                  BPRecoverEN;
  logic [AN-1:0][PW-1:0] archi_maptable;
  logic [AN-1:0][PW-1:0] map_array_disp;
  logic [AN-1:0]         ready_array_disp;

  always #5 clock = ~clock;

  map_table_nway #(.DISPATCH_W(DW), .CDB_W(CW), .AR_NUM(AN), .PR_W(PW)) dut (
    .clock(clock), .reset(reset),
    .dispatch_en(dispatch_en), .maptable_new_ar(maptable_new_ar), .maptable_new_pr(maptable_new_pr),
    .reg1_ar(reg1_ar), .reg2_ar(reg2_ar),
    .reg1_tag(reg1_tag), .reg2_tag(reg2_tag),
    .reg1_ready(reg1_ready), .reg2_ready(reg2_ready),
    .Told_out(Told_out), .cdb_tag(cdb_tag), .BPRecoverEN(BPRecoverEN),
    .archi_maptable(archi_maptable),
    .map_array_disp(map_array_disp), .ready_array_disp(ready_array_disp)
  );

  int checks = 0;
  int errors = 0;

  // Reference state and per-cycle expectations
  int mmap [AN];
  bit mrdy [AN];
  int n_map [AN];
  bit n_rdy [AN];
  int e_r1tag [DW], e_r2tag [DW], e_told [DW];
  bit e_r1rdy [DW], e_r2rdy [DW];

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
    end
  endtask

  function automatic bit on_cdb(input int t);
    on_cdb = 1'b0;
    for (int k = 0; k < CW; k++)
      if (t != 0 && int'(cdb_tag[k]) == t) on_cdb = 1'b1;
  endfunction

  // Instructions execute in program order (oldest slot first) against a working copy.
  task automatic model_eval();
    int wm [AN];
    bit wr [AN];
    for (int i = 0; i < AN; i++) begin
      wm[i] = mmap[i];
      wr[i] = mrdy[i] || on_cdb(mmap[i]);
    end
    for (int s = DW-1; s >= 0; s--) begin
      e_r1tag[s] = (reg1_ar[s] == 0) ? 0 : wm[reg1_ar[s]];
      e_r1rdy[s] = (reg1_ar[s] == 0) ? 1'b1 : wr[reg1_ar[s]];
      e_r2tag[s] = (reg2_ar[s] == 0) ? 0 : wm[reg2_ar[s]];
      e_r2rdy[s] = (reg2_ar[s] == 0) ? 1'b1 : wr[reg2_ar[s]];
      e_told[s]  = (maptable_new_ar[s] == 0) ? 0 : wm[maptable_new_ar[s]];
      if (dispatch_en[s] && maptable_new_ar[s] != 0) begin
        wm[maptable_new_ar[s]] = maptable_new_pr[s];
        wr[maptable_new_ar[s]] = 1'b0;
      end
    end
    for (int i = 0; i < AN; i++) begin
      if (reset) begin
        n_map[i] = i;
        n_rdy[i] = 1'b1;
      end else if (BPRecoverEN) begin
        n_map[i] = archi_maptable[i];
        n_rdy[i] = 1'b1;
      end else begin
        n_map[i] = wm[i];
        n_rdy[i] = wr[i];
      end
    end
  endtask

  task automatic eval_check();
    logic [AN-1:0] exp_rdy;
    #1;
    model_eval();
    for (int s = 0; s < DW; s++) begin
      chk($sformatf("reg1_tag[%0d]", s), reg1_tag[s], e_r1tag[s]);
      chk($sformatf("reg1_ready[%0d]", s), reg1_ready[s], e_r1rdy[s]);
      chk($sformatf("reg2_tag[%0d]", s), reg2_tag[s], e_r2tag[s]);
      chk($sformatf("reg2_ready[%0d]", s), reg2_ready[s], e_r2rdy[s]);
      chk($sformatf("Told_out[%0d]", s), Told_out[s], e_told[s]);
    end
    for (int i = 0; i < AN; i++) begin
      chk($sformatf("map[%0d]", i), map_array_disp[i], mmap[i]);
      exp_rdy[i] = mrdy[i];
    end
    chk("ready_array", ready_array_disp, exp_rdy);
  endtask

  task automatic tick();
    @(posedge clock);
    for (int i = 0; i < AN; i++) begin
      mmap[i] = n_map[i];
      mrdy[i] = n_rdy[i];
    end
    @(negedge clock);
  endtask

  task automatic clear_inputs();
    dispatch_en = '0; maptable_new_ar = '0; maptable_new_pr = '0;
    reg1_ar = '0; reg2_ar = '0; cdb_tag = '0; BPRecoverEN = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    for (int i = 0; i < AN; i++) archi_maptable[i] = PW'(i);
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < AN; i++) begin
      mmap[i] = i;
      mrdy[i] = 1'b1;
    end

    // Reset state, then three independent renames
    dispatch_en = 3'b111;
    maptable_new_ar[2] = 5'd1; maptable_new_pr[2] = 6'd33;
    maptable_new_ar[1] = 5'd2; maptable_new_pr[1] = 6'd34;
    maptable_new_ar[0] = 5'd3; maptable_new_pr[0] = 6'd35;
    reg1_ar[2] = 5'd15; reg1_ar[1] = 5'd17; reg1_ar[0] = 5'd15;
    eval_check();
    chk("rst_map5", map_array_disp[5], 5);
    chk("rst_ready", ready_array_disp, 32'hFFFF_FFFF);
    chk("t1_reg1_tag1", reg1_tag[1], 17);
    chk("t1_reg1_ready", reg1_ready, 3'b111);
    chk("t1_told2", Told_out[2], 1);
    chk("t1_told0", Told_out[0], 3);
    tick();
    chk("t1_map1", map_array_disp[1], 33);
    chk("t1_map3", map_array_disp[3], 35);
    chk("t1_ready321", ready_array_disp[3:1], 0);

    // Intra-bundle forwarding
    clear_inputs();
    dispatch_en = 3'b101;
    maptable_new_ar[2] = 5'd4; maptable_new_pr[2] = 6'd36;
    maptable_new_ar[0] = 5'd4; maptable_new_pr[0] = 6'd37;
    reg1_ar[1] = 5'd4;
    eval_check();
    chk("t2_reg1_tag1", reg1_tag[1], 36);
    chk("t2_reg1_ready1", reg1_ready[1], 0);
    chk("t2_told0", Told_out[0], 36);
    chk("t2_told2", Told_out[2], 4);
    tick();
    chk("t2_map4", map_array_disp[4], 37);

    // CDB bypass
    clear_inputs();
    cdb_tag[2] = 6'd33;
    reg2_ar[0] = 5'd1;
    eval_check();
    chk("t3_reg2_tag0", reg2_tag[0], 33);
    chk("t3_reg2_ready0", reg2_ready[0], 1);
    tick();
    chk("t3_ready1", ready_array_disp[1], 1);

    // Rename overrides a same-cycle CDB set
    clear_inputs();
    cdb_tag[2] = 6'd34;
    dispatch_en = 3'b001;
    maptable_new_ar[0] = 5'd2; maptable_new_pr[0] = 6'd40;
    eval_check();
    tick();
    chk("t4_map2", map_array_disp[2], 40);
    chk("t4_ready2", ready_array_disp[2], 0);

    // Branch recovery drops concurrent dispatch
    clear_inputs();
    for (int i = 0; i < AN; i++) archi_maptable[i] = PW'(i + 32);
    BPRecoverEN = 1'b1;
    dispatch_en = 3'b111;
    maptable_new_ar[2] = 5'd10; maptable_new_pr[2] = 6'd50;
    maptable_new_ar[1] = 5'd11; maptable_new_pr[1] = 6'd51;
    maptable_new_ar[0] = 5'd12; maptable_new_pr[0] = 6'd52;
    cdb_tag[0] = 6'd40;
    eval_check();
    tick();
    chk("t5_map10", map_array_disp[10], 42);
    chk("t5_map31", map_array_disp[31], 63);
    chk("t5_ready", ready_array_disp, 32'hFFFF_FFFF);

    // Randomized traffic with occasional recovery and one mid-run reset
    for (int c = 0; c < 400; c++) begin
      clear_inputs();
      reset = (c == 200);
      dispatch_en = DW'($urandom);
      for (int s = 0; s < DW; s++) begin
        maptable_new_ar[s] = ($urandom % 3 == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
        maptable_new_pr[s] = PW'($urandom_range(1, 63));
        reg1_ar[s] = AW'($urandom_range(0, 7));
        reg2_ar[s] = ($urandom % 2 == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      end
      for (int k = 0; k < CW; k++) begin
        case ($urandom % 4)
          0: cdb_tag[k] = '0;
          1: cdb_tag[k] = PW'($urandom_range(1, 63));
          default: cdb_tag[k] = PW'(mmap[$urandom % AN]);
        endcase
      end
      if ($urandom % 40 == 0) begin
        BPRecoverEN = 1'b1;
        for (int i = 0; i < AN; i++) archi_maptable[i] = PW'($urandom);
      end
      eval_check();
      tick();
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/map_table_nway.md
Name: map_table_nway

Overview:
Parametrised rename map table, the successor to the fixed 3-wide map_table. It maps AR_NUM architectural registers to PR_W-bit physical tags and tracks a ready bit per entry. It resolves intra-bundle dependencies, sets ready bits from a CDB_W-wide tag broadcast with same-cycle bypass, and restores state from the architectural map on branch recovery. It sits between decode/freelist and the RS/ROB in dispatch.

Parameters:
DISPATCH_W, 3, rename slots per cycle; slot DISPATCH_W-1 is the oldest instruction.
CDB_W, 3, completion tags broadcast per cycle.
AR_NUM, 32, architectural registers; AR_W = $clog2(AR_NUM).
PR_W, 6, physical tag width; tag 0 is the null tag.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
dispatch_en  in  DISPATCH_W  per-slot rename valid
maptable_new_ar  in  DISPATCH_W x AR_W  destination AR per slot
maptable_new_pr  in  DISPATCH_W x PR_W  newly allocated PR per slot
reg1_ar, reg2_ar  in  DISPATCH_W x AR_W  source ARs per slot
reg1_tag, reg2_tag  out  DISPATCH_W x PR_W  source PR tags
reg1_ready, reg2_ready  out  DISPATCH_W  source ready flags
Told_out  out  DISPATCH_W x PR_W  previous mapping of each destination
cdb_tag  in  CDB_W x PR_W  completing tags; 0 = no broadcast
BPRecoverEN  in  1  load the architectural map
archi_maptable  in  AR_NUM x PR_W  retirement map
map_array_disp  out  AR_NUM x PR_W  current map (debug)
ready_array_disp  out  AR_NUM  current ready bits (debug)

Behaviour:
- Reset (sampled at posedge): map[i]=i, ready[i]=1 for all i. All outputs are combinational and reflect this state on the following cycle.
- Lookup is combinational with zero latency:
  - Source of slot s returns the youngest mapping among the table and older slots j>s that have dispatch_en[j] and a matching new_ar.
  - A bundle-forwarded source returns tag = maptable_new_pr[j] and ready=0.
  - A table-sourced source returns ready = ready[ar] OR (the tag matches any non-zero cdb_tag this cycle). This is the CDB bypass.
- Told_out[s] uses the same rule for maptable_new_ar[s], excluding slot s itself.
- AR 0 is hardwired:
  - Lookups return tag 0, ready 1.
  - Writes to AR 0 are ignored.
  - Told_out for AR 0 is 0.
- Posedge update, non-recovery:
  - For each entry, ready is set if map[i] matches any non-zero cdb_tag.
  - Then each enabled slot writes map[ar]=new_pr, ready[ar]=0.
  - If several slots write the same AR, the youngest (lowest index) wins.
  - A rename write overrides a CDB set on the same entry in the same cycle.
- BPRecoverEN:
  - Next state is map=archi_maptable, ready all 1.
  - Dispatch and CDB are ignored that cycle.
  - Lookups that cycle still reflect the pre-recovery table and must be discarded upstream.
- Priority: reset > BPRecoverEN > (CDB, then dispatch).
- Duplicate CDB tags within a cycle are harmless. Tags are compared at full PR_W with no truncation.

Optional Feature:
MT_CHECKPOINT_EN.
- When defined, adds ports checkpoint_take (in, 1) and checkpoint_restore (in, 1), plus one snapshot register (map + ready).
- take captures the post-update state of the current cycle, including this cycle's dispatch and CDB.
- Snapshot ready bits keep absorbing CDB tags every cycle.
- restore next-state = snapshot map, with ready = snapshot ready OR this cycle's CDB matches. Dispatch is ignored that cycle.
- Priority: reset > BPRecoverEN > checkpoint_restore > take/dispatch.
- restore and take in the same cycle: restore wins and the snapshot is unchanged.
- When undefined: no extra ports, no snapshot storage, and behaviour is exactly as above.

Decomposition:
- Shared sys_defs package holds:
  - CDB_T_PACKET, generalised to a CDB_W array of PR_W tags.
  - MT_ENTRY struct {pr, ready}.
  - AR_ZERO constant.
  - Default DISPATCH_W/CDB_W/PR_W constants.
- Sub-module mt_bundle_resolve: combinational per-slot older-slot priority search producing the forwarded tag, a hit flag and Told. Instantiate it three times: reg1, reg2 and dest.

Test Plan:
1. Reset, then dispatch slots 2/1/0 = (ar1→33, ar2→34, ar3→35), reg1_ar=15/17/15 → reg1_tag=15/17/15, ready=1/1/1; Told=1/2/3. Next cycle map[1..3]=33/34/35 with ready 0.
2. Intra-bundle: slot2 ar4→36, slot1 reg1_ar=4, slot0 ar4→37 with Told → slot1 reg1_tag=36, ready 0; slot0 Told=36; map[4]=37 next cycle.
3. CDB bypass: map[1]=33 not ready, cdb_tag={33,0,0}, slot0 reg2_ar=1 → reg2_ready=1 same cycle; ready[1]=1 next cycle.
4. Rename/CDB collision: cdb_tag 34 while slot0 renames ar2→40 → map[2]=40, ready[2]=0.
5. BPRecoverEN with archi_maptable[i]=i+32 and concurrent dispatch → map[i]=i+32, all ready, dispatch dropped.
6. (MT_CHECKPOINT_EN) Take after ar5→41, then rename ar5→42, broadcast 41, restore → map[5]=41, ready[5]=1.
